// File: rtl/xe11_dma.sv
`timescale 1ns/1ps
// Unibus NPR master: one ARM-commanded word/byte DATI/DATO cycle per request, status polled or via armintrq.
// Latency: arbitration + DESKEW clocks of address setup + slave response time; TIMEOUT clocks without SSYN gives NXM.
// Backpressure: ARM writes to CMD/STAT and DATA are dropped while busy; software polls busy/done.
//
// Ports: CLOCK/RESET_N (async active-low); ARM register port armwrite/armwaddr/armwdata/armraddr/armrdata/armintrq;
// Unibus side init_in_h, npr/npg, sack, bbsy in/out, msyn/ssyn, a/c/d out, d in.
// Optional feature: define XE11_DMA_AUTOINC_EN to advance the address after each successful transfer.
module xe11_dma #(
    parameter int DESKEW  = 15,
    parameter int TIMEOUT = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        armintrq,
    input  logic        init_in_h,
    output logic        npr_out_h,
    input  logic        npg_in_h,
    output logic        sack_out_h,
    input  logic        bbsy_in_h,
    output logic        bbsy_out_h,
    input  logic        ssyn_in_h,
    output logic        msyn_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    input  logic [15:0] d_in_h
);

    localparam int CW = $clog2(DESKEW + TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SACK, S_DESKEW, S_MSYN, S_UNSYN, S_RELEASE
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           busy, done, nxm, initabt;
    logic [1:0]     c_reg;
    logic [17:0]    addr;
    logic [15:0]    data;
    logic           start, w1c, wr_data;
    logic           set_nxm, latch_rd;
    logic           deskew_end, timed_out;

    assign start   = armwrite && (armwaddr == 2'd1) && armwdata[31] && !busy;
    assign w1c     = armwrite && (armwaddr == 2'd1) && armwdata[30] && !busy;
    assign wr_data = armwrite && (armwaddr == 2'd2) && !busy;

    assign deskew_end = (cnt == CW'(DESKEW - 1));
    assign timed_out  = (cnt == CW'(TIMEOUT - 1));

    assign armintrq = done;

    always_comb begin
        armrdata = 32'h0;
        case (armraddr)
            2'd0:    armrdata = 32'h444D1001;
            2'd1:    armrdata = {busy, done, nxm, initabt, 8'h00, c_reg, addr};
            2'd2:    armrdata = {16'h0000, data};
            default: armrdata = 32'h0;
        endcase
    end

    // Bus outputs are decoded from the state register, so an INIT-forced
    // return to IDLE clears every bus line on the following clock.
    always_comb begin
        state_nxt  = state;
        npr_out_h  = 1'b0;
        sack_out_h = 1'b0;
        bbsy_out_h = 1'b0;
        msyn_out_h = 1'b0;
        a_out_h    = 18'h0;
        c_out_h    = 2'b00;
        d_out_h    = 16'h0;
        set_nxm    = 1'b0;
        latch_rd   = 1'b0;

        if (state == S_DESKEW || state == S_MSYN || state == S_UNSYN) begin
            bbsy_out_h = 1'b1;
            a_out_h    = addr;
            c_out_h    = c_reg;
            // Only DATO/DATOB put data on the bus; byte lane placement is software's job.
            d_out_h    = c_reg[1] ? data : 16'h0;
        end

        case (state)
            S_IDLE:    if (start) state_nxt = S_REQ;
            S_REQ: begin
                npr_out_h = 1'b1;
                if (npg_in_h) state_nxt = S_SACK;
            end
            S_SACK: begin
                sack_out_h = 1'b1;
                // Previous master must be fully off the bus before we take it.
                if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) state_nxt = S_DESKEW;
            end
            S_DESKEW:  if (deskew_end) state_nxt = S_MSYN;
            S_MSYN: begin
                msyn_out_h = 1'b1;
                if (ssyn_in_h) begin
                    latch_rd  = !c_reg[1];
                    state_nxt = S_UNSYN;
                end else if (timed_out) begin
                    set_nxm   = 1'b1;
                    state_nxt = S_RELEASE;
                end
            end
            S_UNSYN: begin
                if (!ssyn_in_h) begin
                    state_nxt = S_RELEASE;
                end else if (timed_out) begin
                    set_nxm   = 1'b1;
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase

        if (init_in_h) begin
            state_nxt = S_IDLE;
            set_nxm   = 1'b0;
            latch_rd  = 1'b0;
        end
    end

    // cnt restarts on every state change: it serves as deskew counter and SSYN timeout.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            nxm     <= 1'b0;
            initabt <= 1'b0;
            c_reg   <= 2'b00;
            addr    <= 18'h0;
            data    <= 16'h0;
        end else if (init_in_h) begin
            if (busy) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                initabt <= 1'b1;
            end
        end else begin
            if (start) begin
                c_reg   <= armwdata[19:18];
                addr    <= armwdata[17:0];
                busy    <= 1'b1;
                done    <= 1'b0;
                nxm     <= 1'b0;
                initabt <= 1'b0;
            end else if (w1c) begin
                done    <= 1'b0;
                nxm     <= 1'b0;
                initabt <= 1'b0;
            end
            if (wr_data)  data <= armwdata[15:0];
            if (latch_rd) data <= d_in_h;
            if (set_nxm)  nxm  <= 1'b1;
            if (state == S_RELEASE) begin
                busy <= 1'b0;
                done <= 1'b1;
`ifdef XE11_DMA_AUTOINC_EN
                if (!nxm) addr <= addr + ((c_reg == 2'b11) ? 18'd1 : 18'd2);
`endif
            end
        end
    end

endmodule
